// File: rtl/pipe_pkg.sv
// Shared constants and helpers for the pipeline stage buffer.
package pipe_pkg;

  // Bubble encoding: sll $0,$0,0 is the all-zero word.
  localparam logic [31:0] NOP_ENC = 32'h0000_0000;

  localparam int DEFAULT_PC_W   = 32;
  localparam int DEFAULT_DATA_W = 32;

  // Occupancy is at most 2 beats (main + skid), so two bits are enough.
  localparam int OCC_W = 2;

  typedef logic [OCC_W-1:0] occ_t;

  // Number of held beats from the two entry valid bits.
  function automatic occ_t occupancyOf(input logic mainValid, input logic skidValid);
    return occ_t'({1'b0, mainValid}) + occ_t'({1'b0, skidValid});
  endfunction

endpackage

// File: rtl/pipe_stage_buf_if.sv
// Valid/ready handshake bundle for the upstream and downstream sides of a stage.
interface pipe_stage_buf_if #(
  parameter int PC_W   = 32,
  parameter int DATA_W = 32
) ();

  logic              InValid;
  logic              InReady;
  logic [PC_W-1:0]   InPC;
  logic [DATA_W-1:0] InData;
  logic              OutValid;
  logic              OutReady;
  logic [PC_W-1:0]   OutPC;
  logic [DATA_W-1:0] OutData;

  // The environment around the stage: offers beats and accepts results.
  modport master (
    output InValid, InPC, InData, OutReady,
    input  InReady, OutValid, OutPC, OutData
  );

  // The stage itself.
  modport slave (
    input  InValid, InPC, InData, OutReady,
    output InReady, OutValid, OutPC, OutData
  );

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear, used for performance debug counts.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             Clk,
  input  logic             Clear,
  input  logic             Inc,
  output logic [WIDTH-1:0] Count
);

  logic [WIDTH-1:0] count_q;

  // Count up on Inc, stick at all-ones instead of wrapping; Clear wins.
  always_ff @(posedge Clk) begin
    if (Clear) begin
      count_q <= '0;
    end else if (Inc && (count_q != {WIDTH{1'b1}})) begin
      count_q <= count_q + WIDTH'(1);
    end
  end

  assign Count = count_q;

endmodule

// File: rtl/pipe_stage_buf.sv
// Pipeline stage register with valid/ready handshake, flush-to-bubble and an
// optional skid entry so InReady can be a flop output instead of a comb path.
module pipe_stage_buf
  import pipe_pkg::*;
#(
  parameter int                DATA_W   = DEFAULT_DATA_W,
  parameter int                PC_W     = DEFAULT_PC_W,
  parameter bit                SKID_EN  = 1'b1,
  parameter logic [DATA_W-1:0] NOP_WORD = DATA_W'(NOP_ENC),
  parameter int                CNT_W    = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Flush,
  pipe_stage_buf_if.slave  Bus,
  output logic [OCC_W-1:0] Occupancy,
  output logic [CNT_W-1:0] StallCount,
  output logic [CNT_W-1:0] FlushCount
);

  logic              mainValid_q, mainValid_d;
  logic [PC_W-1:0]   mainPc_q,    mainPc_d;
  logic [DATA_W-1:0] mainData_q,  mainData_d;
  logic              skidValid_q, skidValid_d;
  logic [PC_W-1:0]   skidPc_q,    skidPc_d;
  logic [DATA_W-1:0] skidData_q,  skidData_d;

  logic inFire;
  logic outFire;
  logic stallInc;
  logic flushInc;

  // With the skid entry InReady is just the inverted skid valid flop; without
  // it the stage behaves as a classic latch that can refill while draining.
  assign Bus.InReady = SKID_EN ? !skidValid_q : (!mainValid_q || Bus.OutReady);

  assign inFire  = Bus.InValid && Bus.InReady;
  assign outFire = mainValid_q && Bus.OutReady;

  // Next-state for both entries: flush kills everything, otherwise the head
  // refills from skid first (older beat), then from upstream, else goes bubble.
  always_comb begin
    mainValid_d = mainValid_q;
    mainPc_d    = mainPc_q;
    mainData_d  = mainData_q;
    skidValid_d = skidValid_q;
    skidPc_d    = skidPc_q;
    skidData_d  = skidData_q;

    if (Flush) begin
      mainValid_d = 1'b0;
      mainData_d  = NOP_WORD;
      skidValid_d = 1'b0;
    end else if (!mainValid_q || outFire) begin
      if (skidValid_q) begin
        mainValid_d = 1'b1;
        mainPc_d    = skidPc_q;
        mainData_d  = skidData_q;
        skidValid_d = 1'b0;
      end else if (inFire) begin
        mainValid_d = 1'b1;
        mainPc_d    = Bus.InPC;
        mainData_d  = Bus.InData;
      end else begin
        mainValid_d = 1'b0;
        mainData_d  = NOP_WORD;
      end
    end else if (inFire && SKID_EN) begin
      skidValid_d = 1'b1;
      skidPc_d    = Bus.InPC;
      skidData_d  = Bus.InData;
    end
  end

  // Entry registers; reset empties both and parks the outputs on a bubble.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      mainValid_q <= 1'b0;
      mainPc_q    <= '0;
      mainData_q  <= NOP_WORD;
      skidValid_q <= 1'b0;
      skidPc_q    <= '0;
      skidData_q  <= NOP_WORD;
    end else begin
      mainValid_q <= mainValid_d;
      mainPc_q    <= mainPc_d;
      mainData_q  <= mainData_d;
      skidValid_q <= skidValid_d;
      skidPc_q    <= skidPc_d;
      skidData_q  <= skidData_d;
    end
  end

  assign Bus.OutValid = mainValid_q;
  assign Bus.OutPC    = mainPc_q;
  assign Bus.OutData  = mainData_q;
  assign Occupancy    = occupancyOf(mainValid_q, skidValid_q);

  assign stallInc = mainValid_q && !Bus.OutReady;
  assign flushInc = Flush && (Occupancy != '0);

  sat_counter #(.WIDTH(CNT_W)) uStallCounter (
    .Clk   (Clk),
    .Clear (Reset),
    .Inc   (stallInc),
    .Count (StallCount)
  );

  sat_counter #(.WIDTH(CNT_W)) uFlushCounter (
    .Clk   (Clk),
    .Clear (Reset),
    .Inc   (flushInc),
    .Count (FlushCount)
  );

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed self-checking bench: skid variant (dutA) and single-entry variant (dutB).
module tb_pipe_stage_buf;
  import pipe_pkg::*;

  localparam int                DW  = 32;
  localparam int                PW  = 16;
  localparam int                CW  = 4;
  localparam logic [DW-1:0]     NOP = 32'hDEAD_0013;

  logic Clk;
  logic Reset;
  logic Flush;

  logic [OCC_W-1:0] occA, occB;
  logic [CW-1:0]    stallA, stallB, flushA, flushB;

  int checks = 0;
  int errors = 0;

  pipe_stage_buf_if #(.PC_W(PW), .DATA_W(DW)) busA ();
  pipe_stage_buf_if #(.PC_W(PW), .DATA_W(DW)) busB ();

  pipe_stage_buf #(.DATA_W(DW), .PC_W(PW), .SKID_EN(1'b1), .NOP_WORD(NOP), .CNT_W(CW)) dutA (
    .Clk(Clk), .Reset(Reset), .Flush(Flush), .Bus(busA),
    .Occupancy(occA), .StallCount(stallA), .FlushCount(flushA)
  );

  pipe_stage_buf #(.DATA_W(DW), .PC_W(PW), .SKID_EN(1'b0), .NOP_WORD(NOP), .CNT_W(CW)) dutB (
    .Clk(Clk), .Reset(Reset), .Flush(Flush), .Bus(busB),
    .Occupancy(occB), .StallCount(stallB), .FlushCount(flushB)
  );

  // Free-running clock, 10 time units per cycle.
  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  // Advance one edge and settle just after it.
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    checks++; if (busA.OutValid !== 1'b0) begin errors++; $display("[TB] FAIL rst_valid got %b exp 0", busA.OutValid); end
    checks++; if (busA.OutData !== NOP) begin errors++; $display("[TB] FAIL rst_data got %h exp %h", busA.OutData, NOP); end
    checks++; if (busA.OutPC !== 16'h0) begin errors++; $display("[TB] FAIL rst_pc got %h exp 0", busA.OutPC); end
    checks++; if (occA !== 2'd0) begin errors++; $display("[TB] FAIL rst_occ got %0d exp 0", occA); end
    checks++; if (busA.InReady !== 1'b1) begin errors++; $display("[TB] FAIL rst_inready got %b exp 1", busA.InReady); end
    checks++; if (stallA !== 4'd0 || flushA !== 4'd0) begin errors++; $display("[TB] FAIL rst_cnt got %0d/%0d exp 0/0", stallA, flushA); end
  endtask

  task automatic test_reset_midstream();
    busA.OutReady = 1'b0;
    busA.InValid  = 1'b1;
    busA.InPC = 16'h0100; busA.InData = 32'h1111_0100;
    tick();
    busA.InPC = 16'h0104; busA.InData = 32'h1111_0104;
    tick();
    busA.InValid = 1'b0;
    checks++; if (occA !== 2'd2) begin errors++; $display("[TB] FAIL mid_fill_occ got %0d exp 2", occA); end
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    checks++; if (busA.OutValid !== 1'b0 || busA.OutData !== NOP) begin errors++; $display("[TB] FAIL mid_rst_out got v=%b d=%h exp v=0 d=%h", busA.OutValid, busA.OutData, NOP); end
    checks++; if (occA !== 2'd0 || busA.InReady !== 1'b1) begin errors++; $display("[TB] FAIL mid_rst_occ got occ=%0d rdy=%b exp 0/1", occA, busA.InReady); end
    checks++; if (stallA !== 4'd0 || flushA !== 4'd0) begin errors++; $display("[TB] FAIL mid_rst_cnt got %0d/%0d exp 0/0", stallA, flushA); end
    busA.OutReady = 1'b1;
  endtask

  task automatic test_streaming();
    busA.OutReady = 1'b1;
    busA.InValid  = 1'b1;
    for (int i = 0; i < 6; i++) begin
      busA.InPC   = PW'(i * 4);
      busA.InData = 32'hA000_0000 + 32'(i);
      tick();
      checks++;
      if (busA.OutValid !== 1'b1 || busA.OutPC !== PW'(i * 4) || busA.OutData !== 32'hA000_0000 + 32'(i) || occA !== 2'd1) begin
        errors++;
        $display("[TB] FAIL stream_%0d got v=%b pc=%h d=%h occ=%0d exp v=1 pc=%h d=%h occ=1", i, busA.OutValid, busA.OutPC, busA.OutData, occA, PW'(i * 4), 32'hA000_0000 + 32'(i));
      end
    end
    busA.InValid = 1'b0;
    tick();
    checks++; if (busA.OutValid !== 1'b0 || busA.OutData !== NOP || occA !== 2'd0) begin errors++; $display("[TB] FAIL stream_drain got v=%b d=%h occ=%0d exp 0/%h/0", busA.OutValid, busA.OutData, occA, NOP); end
    checks++; if (stallA !== 4'd0) begin errors++; $display("[TB] FAIL stream_stall got %0d exp 0", stallA); end
  endtask

  task automatic test_backpressure();
    busA.OutReady = 1'b0;
    busA.InValid  = 1'b1;
    busA.InPC = 16'h0010; busA.InData = 32'hB000_0010;
    tick();
    busA.InPC = 16'h0014; busA.InData = 32'hB000_0014;
    tick();
    checks++; if (busA.InReady !== 1'b0 || occA !== 2'd2) begin errors++; $display("[TB] FAIL bp_full got rdy=%b occ=%0d exp 0/2", busA.InReady, occA); end
    busA.InPC = 16'h0018; busA.InData = 32'hB000_0018;
    tick();
    tick();
    checks++; if (stallA !== 4'd3) begin errors++; $display("[TB] FAIL bp_stall got %0d exp 3", stallA); end
    checks++; if (busA.OutPC !== 16'h0010 || busA.OutData !== 32'hB000_0010 || busA.OutValid !== 1'b1) begin errors++; $display("[TB] FAIL bp_hold got pc=%h d=%h exp 0010/b0000010", busA.OutPC, busA.OutData); end
    busA.OutReady = 1'b1;
    tick();
    checks++; if (busA.OutPC !== 16'h0014 || busA.OutData !== 32'hB000_0014 || occA !== 2'd1 || busA.InReady !== 1'b1) begin errors++; $display("[TB] FAIL bp_rel1 got pc=%h occ=%0d rdy=%b exp 0014/1/1", busA.OutPC, occA, busA.InReady); end
    tick();
    busA.InValid = 1'b0;
    checks++; if (busA.OutPC !== 16'h0018 || busA.OutData !== 32'hB000_0018 || busA.OutValid !== 1'b1) begin errors++; $display("[TB] FAIL bp_rel2 got pc=%h d=%h exp 0018/b0000018", busA.OutPC, busA.OutData); end
    tick();
    checks++; if (busA.OutValid !== 1'b0 || stallA !== 4'd3) begin errors++; $display("[TB] FAIL bp_end got v=%b stall=%0d exp 0/3", busA.OutValid, stallA); end
  endtask

  task automatic test_flush_full();
    busA.OutReady = 1'b0;
    busA.InValid  = 1'b1;
    busA.InPC = 16'h0030; busA.InData = 32'hC000_0030;
    tick();
    busA.InPC = 16'h0034; busA.InData = 32'hC000_0034;
    tick();
    busA.InPC = 16'h0040; busA.InData = 32'hC000_0040;
    Flush = 1'b1;
    tick();
    Flush = 1'b0;
    busA.InValid = 1'b0;
    checks++; if (busA.OutValid !== 1'b0 || busA.OutData !== NOP || occA !== 2'd0) begin errors++; $display("[TB] FAIL flush_full got v=%b d=%h occ=%0d exp 0/%h/0", busA.OutValid, busA.OutData, occA, NOP); end
    checks++; if (flushA !== 4'd1) begin errors++; $display("[TB] FAIL flush_full_cnt got %0d exp 1", flushA); end
    checks++; if (busA.OutPC !== 16'h0030) begin errors++; $display("[TB] FAIL flush_pc_hold got %h exp 0030", busA.OutPC); end
    busA.OutReady = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (busA.OutValid !== 1'b0) begin errors++; $display("[TB] FAIL flush_ghost_%0d got v=%b pc=%h exp v=0", i, busA.OutValid, busA.OutPC); end
    end
    // One held beat plus an accepted offer: both must vanish.
    busA.InValid = 1'b1;
    busA.InPC = 16'h0050; busA.InData = 32'hC000_0050;
    tick();
    busA.InPC = 16'h0054; busA.InData = 32'hC000_0054;
    Flush = 1'b1;
    tick();
    Flush = 1'b0;
    busA.InValid = 1'b0;
    checks++; if (busA.OutValid !== 1'b0 || flushA !== 4'd2) begin errors++; $display("[TB] FAIL flush_one got v=%b pc=%h cnt=%0d exp 0/-/2", busA.OutValid, busA.OutPC, flushA); end
    tick();
    checks++; if (busA.OutValid !== 1'b0) begin errors++; $display("[TB] FAIL flush_one_ghost got v=%b pc=%h exp v=0", busA.OutValid, busA.OutPC); end
  endtask

  task automatic test_flush_empty();
    Flush = 1'b1;
    tick();
    Flush = 1'b0;
    checks++; if (flushA !== 4'd2 || occA !== 2'd0) begin errors++; $display("[TB] FAIL flush_empty got cnt=%0d occ=%0d exp 2/0", flushA, occA); end
  endtask

  task automatic test_saturation();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    busA.OutReady = 1'b1;
    busA.InValid  = 1'b1;
    busA.InPC = 16'h0060; busA.InData = 32'hD000_0060;
    tick();
    busA.InValid  = 1'b0;
    busA.OutReady = 1'b0;
    repeat (20) tick();
    checks++; if (stallA !== 4'd15) begin errors++; $display("[TB] FAIL sat_a got %0d exp 15", stallA); end
    repeat (2) tick();
    checks++; if (stallA !== 4'd15) begin errors++; $display("[TB] FAIL sat_a_hold got %0d exp 15", stallA); end
    checks++; if (busA.OutPC !== 16'h0060 || busA.OutData !== 32'hD000_0060 || busA.OutValid !== 1'b1) begin errors++; $display("[TB] FAIL sat_a_stable got pc=%h d=%h exp 0060/d0000060", busA.OutPC, busA.OutData); end
    busA.OutReady = 1'b1;
    tick();
  endtask

  task automatic test_no_skid();
    busB.OutReady = 1'b1;
    busB.InValid  = 1'b1;
    busB.InPC = 16'h0070; busB.InData = 32'hE000_0070;
    tick();
    busB.InValid  = 1'b0;
    busB.OutReady = 1'b0;
    #1;
    checks++; if (busB.InReady !== 1'b0) begin errors++; $display("[TB] FAIL b_rdy_low got %b exp 0", busB.InReady); end
    busB.OutReady = 1'b1;
    #1;
    checks++; if (busB.InReady !== 1'b1) begin errors++; $display("[TB] FAIL b_rdy_comb got %b exp 1", busB.InReady); end
    busB.OutReady = 1'b0;
    busB.InValid  = 1'b1;
    busB.InPC = 16'h0074; busB.InData = 32'hE000_0074;
    tick();
    checks++; if (occB !== 2'd1 || busB.OutPC !== 16'h0070) begin errors++; $display("[TB] FAIL b_stall got occ=%0d pc=%h exp 1/0070", occB, busB.OutPC); end
    busB.OutReady = 1'b1;
    tick();
    busB.InValid = 1'b0;
    checks++; if (busB.OutPC !== 16'h0074 || busB.OutData !== 32'hE000_0074 || occB !== 2'd1) begin errors++; $display("[TB] FAIL b_refill got pc=%h d=%h occ=%0d exp 0074/e0000074/1", busB.OutPC, busB.OutData, occB); end
    busB.OutReady = 1'b0;
    repeat (20) tick();
    checks++; if (stallB !== 4'd15) begin errors++; $display("[TB] FAIL sat_b got %0d exp 15", stallB); end
    busB.OutReady = 1'b1;
    tick();
    checks++; if (busB.OutValid !== 1'b0 || busB.OutData !== NOP) begin errors++; $display("[TB] FAIL b_drain got v=%b d=%h exp 0/%h", busB.OutValid, busB.OutData, NOP); end
  endtask

  // Scenario sequence.
  initial begin
    Reset = 1'b1;
    Flush = 1'b0;
    busA.InValid = 1'b0; busA.InPC = '0; busA.InData = '0; busA.OutReady = 1'b1;
    busB.InValid = 1'b0; busB.InPC = '0; busB.InData = '0; busB.OutReady = 1'b1;
    test_reset();
    test_reset_midstream();
    test_streaming();
    test_backpressure();
    test_flush_full();
    test_flush_empty();
    test_saturation();
    test_no_skid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_stage_buf.md
Name: pipe_stage_buf

Overview:
Parametrised pipeline stage register with a valid/ready handshake. It is the next-generation replacement for the fixed 32-bit IF/ID latch.
- Carries a PC field and an instruction/payload field between any two datapath stages.
- Adds per-entry valid bits, flush with NOP (bubble) insertion, and an optional 2-entry skid buffer, so backpressure never needs a combinational ready path.
- Saturating stall and flush counters for performance debug.

Parameters:
DATA_W, 32, width of instruction/payload field
PC_W, 32, width of PC field
SKID_EN, 1, 1 = two entries (main + skid), InReady registered; 0 = single entry, InReady combinational
NOP_WORD, 0, value driven on OutData whenever OutValid=0 (bubble encoding)
CNT_W, 16, width of the performance counters

Ports:
Clk  in  1  single clock; all state updates on posedge
Reset  in  1  synchronous, active-high; sampled on posedge Clk
InValid  in  1  upstream beat present
InReady  out  1  stage can accept a beat this cycle
InPC  in  PC_W  upstream PC
InData  in  DATA_W  upstream instruction/payload
Flush  in  1  kill all held beats and any beat offered this cycle
OutValid  out  1  OutPC/OutData hold a live beat
OutReady  in  1  downstream accepts the beat this cycle
OutPC  out  PC_W  PC of head beat
OutData  out  DATA_W  payload of head beat, NOP_WORD when not valid
Occupancy  out  2  number of held beats (0..2; max 1 when SKID_EN=0)
StallCount  out  CNT_W  cycles with OutValid=1 and OutReady=0
FlushCount  out  CNT_W  Flush events that killed at least one valid beat

Behaviour:
- Reset, on a posedge with Reset=1:
  - main and skid entries become invalid.
  - OutValid=0, OutPC=0, OutData=NOP_WORD, Occupancy=0.
  - StallCount=0, FlushCount=0.
  - InReady=1 from the first cycle after reset.
- Handshakes: in_fire = InValid & InReady; out_fire = OutValid & OutReady. Beats leave in arrival order; no beat is duplicated or dropped except by Flush.
- Latency: 1 cycle. A beat accepted at edge N appears on OutPC/OutData with OutValid=1 after edge N.
- OutPC, OutData and OutValid come straight from the main entry register. No combinational path from In* to Out*.
- SKID_EN=1:
  - InReady is registered, equal to !skid_valid.
  - On out_fire with skid valid, skid moves to main.
  - in_fire goes to main if main is empty or leaving this cycle; otherwise it goes to skid.
  - Occupancy 2 implies InReady=0 next cycle.
  - Simultaneous in_fire and out_fire at Occupancy 2 cannot occur because InReady=0.
  - Simultaneous in_fire and out_fire at Occupancy 1 keeps Occupancy 1.
- SKID_EN=0: InReady = !OutValid | OutReady (combinational from OutReady). Behaves like a classic stall latch, with stall expressed as OutReady=0.
- Flush (Reset=0, Flush=1):
  - Main and skid are invalidated at that edge.
  - Any beat offered in the same cycle is discarded. InReady is unaffected; the beat counts as consumed upstream.
  - OutData becomes NOP_WORD and OutPC holds its last value.
  - Flush takes priority over in_fire and out_fire.
- Priority: Reset > Flush > normal transfer.
- StallCount: +1 on each edge with OutValid=1 and OutReady=0. Saturates at all-ones and never wraps.
- FlushCount: +1 on each Flush edge where Occupancy > 0. Saturates.
- OutData/OutPC are stable while OutValid=1 and OutReady=0, with no change until out_fire.

Decomposition:
- Shared package pipe_pkg holds:
  - NOP encoding constant (32'h0000_0000, sll $0,$0,0).
  - Default PC_W/DATA_W.
  - A localparam for occupancy width.
- One natural sub-module: sat_counter (width CNT_W; inc, clear; saturating). Instantiate it twice for StallCount and FlushCount.

Test Plan:
- Reset mid-stream: fill to Occupancy 2, assert Reset one cycle. Expect next cycle OutValid=0, OutData=NOP_WORD, Occupancy=0, both counters 0, InReady=1.
- Streaming: InValid=1 and OutReady=1 continuously with PC 0x0,0x4,0x8,... Expect the same sequence on OutPC one cycle later, Occupancy constant 1, StallCount 0.
- Backpressure (SKID_EN=1): drop OutReady for 3 cycles while sending PCs 0x10,0x14,0x18.
  - Expect 0x10 held on the outputs, 0x14 in skid, InReady=0 after the second accept, 0x18 held upstream.
  - StallCount=3.
  - On release, order 0x10,0x14,0x18 with no loss.
- Flush with full buffer: Occupancy 2 plus an offered beat PC 0x40, Flush=1. Expect next cycle OutValid=0, OutData=NOP_WORD, Occupancy=0, FlushCount=1, and 0x40 never appears.
- Flush when empty: Flush=1 with Occupancy 0. Expect FlushCount unchanged.
- Counter saturation: CNT_W=4, hold OutValid=1/OutReady=0 for 20 cycles. Expect StallCount=15 and held there. Repeat with SKID_EN=0 and check InReady tracks OutReady combinationally.
